load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit of the 16-bit MIPS-style pipeline. It sits between the execute stage and the byte-addressed data memory. It accepts one load or store request at a time over a valid/ready handshake and checks alignment and range. It then drives a single one-cycle memory access, captures the registered read data, and returns a sign- or zero-extended load result to write-back over a second valid/ready handshake.

## Interface
- MEM_BYTES, 512: data memory size in bytes; valid byte addresses are 0..MEM_BYTES-1.
- FCNT_W, 8: width of the saturating fault counter.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  execute stage presents a request
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_byte  in  1  1 = byte access, 0 = 16-bit word access
- req_signed  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  16  byte address
- req_wdata  in  16  store data
- req_rd  in  3  destination register tag, returned unchanged
- resp_valid  out  1  response available
- resp_ready  in  1  write-back accepts the response
- resp_data  out  16  extended load data; 0 for stores and faults
- resp_rd  out  3  tag of the completed request
- resp_load  out  1  completed request was a load
- resp_fault  out  1  request was rejected and no memory access was made
- fault_count  out  FCNT_W  saturating count of faulted requests
- dm_enable, mem_read, mem_write, mem_byte  out  1 each  data-memory controls
- mem_address  out  16  data-memory address
- mem_data_in  out  16  data-memory write data
- mem_data_out  in  16  data-memory registered read data

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP.
- Request latch: a request is accepted on the edge where req_valid && req_ready.
  - On acceptance, latch write, byte, signed, addr, wdata and rd.
- Fault check at acceptance:
  - A word access with addr[0]=1 faults.
  - A byte access with addr >= MEM_BYTES faults.
  - A word access with addr > MEM_BYTES-2 faults.
  - Both loads and stores are checked.
- IDLE transitions on acceptance:
  - A faulted request goes directly to RESP.
  - Any other request goes to ISSUE.
- ISSUE lasts exactly one cycle and drives:
  - dm_enable=1.
  - mem_read=!write and mem_write=write.
  - mem_byte=byte.
  - mem_address=latched addr.
  - mem_data_in = byte ? {8'h00, wdata[7:0]} : wdata.
- ISSUE exits: a store goes to RESP; a load goes to CAPTURE.
- CAPTURE, one cycle:
  - Sample mem_data_out; the memory presents read data only in the cycle after the read edge and drives 0 otherwise.
  - A word load registers the sampled value as-is.
  - A byte load registers the sampled low byte, sign-extended if signed is set, otherwise zero-extended.
  - Next state is RESP.
- RESP:
  - resp_valid=1 with resp_data, resp_rd, resp_load and resp_fault held stable.
  - The state holds until resp_ready=1, then goes to IDLE.
  - resp_valid drops on that edge.
- Outside ISSUE: dm_enable, mem_read and mem_write are 0. mem_address and mem_data_in may hold the latched values.
- fault_count increments by 1 on each faulted acceptance and saturates at all-ones.
- At most one request is outstanding. req_ready=0 in ISSUE, CAPTURE and RESP, including the RESP handshake cycle.

## Timing
- Reset values:
  - state=IDLE, so req_ready=1.
  - resp_valid=0, resp_data=0, resp_rd=0, resp_load=0, resp_fault=0.
  - fault_count=0.
  - All mem_* outputs are 0.
- Latency, counted as cycles after the acceptance edge with resp_ready held high:
  - Store: ISSUE in cycle 1, resp_valid in cycle 2.
  - Load: ISSUE in cycle 1, CAPTURE in cycle 2, resp_valid in cycle 3.
  - Fault: resp_valid in cycle 1.
- Throughput with no backpressure:
  - One load per 4 cycles.
  - One store per 3 cycles.
  - One fault per 2 cycles.
- Memory control pulses are exactly one clock wide per non-faulted request and never repeat.
- Backpressure: resp_valid and all resp_* outputs stay stable while resp_ready=0, for any number of cycles.
- Reset mid-operation:
  - rst_n low forces all mem_* outputs to 0 immediately, because the reset is asynchronous.
  - A store whose ISSUE cycle is cut by reset before its edge must not write memory.
  - The pending response is discarded, and fault_count clears.
- req_valid is ignored whenever req_ready=0; the execute stage must hold the request until acceptance.

## Test plan
- Word store then load:
  - Store 0xBEEF to 0x0010, then load word 0x0010.
  - Memory bytes must be 0x10=0xEF and 0x11=0xBE.
  - resp_data=0xBEEF, resp_valid exactly 3 cycles after the load is accepted.
- Byte load extension:
  - Store byte 0x85 to 0x0021.
  - A signed byte load of 0x0021 returns 0xFF85.
  - An unsigned byte load of 0x0021 returns 0x0085.
  - A word load of 0x0020 has upper byte 0x85.
- Faults:
  - A word load at 0x0011 gives resp_fault=1 and resp_data=0.
  - A byte store at 0x0200 faults, and so does a word store at 0x01FF.
  - No dm_enable pulse occurs in any of these cases, and fault_count ends at 3.
- Backpressure:
  - Complete a load with resp_ready=0 for 5 cycles.
  - Response fields stay constant, req_ready stays 0, and there is one mem_read pulse total.
- Reset mid-store:
  - Assert rst_n=0 during ISSUE of a word store of 0x1234 to 0x0030.
  - Memory at 0x0030 and 0x0031 stays unchanged and all outputs take reset values.
- Fault counter saturation with FCNT_W=2:
  - Issue 5 misaligned word loads.
  - fault_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Memory-stage load/store unit for the 16-bit MIPS-style pipeline. It accepts
// one load or store at a time from execute. It rejects misaligned and
// out-of-range addresses. It performs one single-cycle access to the
// byte-addressed data memory and returns an extended load result to
// write-back.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_*               request handshake from execute (valid/ready)
//   resp_*              response handshake to write-back (valid/ready)
//   fault_count         saturating count of rejected requests
//   dm_enable, mem_*    data-memory access controls; mem_data_out is the
//                       memory's registered read data
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int MEM_BYTES = 512,
  parameter int FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [15:0]       req_addr,
  input  logic [15:0]       req_wdata,
  input  logic [2:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [15:0]       resp_data,
  output logic [2:0]        resp_rd,
  output logic              resp_load,
  output logic              resp_fault,
  output logic [FCNT_W-1:0] fault_count,
  output logic              dm_enable,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte,
  output logic [15:0]       mem_address,
  output logic [15:0]       mem_data_in,
  input  logic [15:0]       mem_data_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  // Highest legal start address for a byte and for a word access.
  localparam logic [15:0] MAX_BYTE_ADDR = 16'(MEM_BYTES - 1);
  localparam logic [15:0] MAX_WORD_ADDR = 16'(MEM_BYTES - 2);
  localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

  state_t              r_state;
  state_t              w_state_next;
  logic                w_accept;
  logic                w_fault;

  logic                r_write;
  logic                r_byte;
  logic                r_signed;
  logic [15:0]         r_addr;
  logic [15:0]         r_wdata;
  logic [2:0]          r_rd;
  logic                r_load;
  logic                r_fault;
  logic [15:0]         r_resp_data;
  logic [FCNT_W-1:0]   r_fault_count;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // A word must be even and its upper byte must also fall inside memory.
  assign w_fault = req_byte ? (req_addr > MAX_BYTE_ADDR)
                            : (req_addr[0] || (req_addr > MAX_WORD_ADDR));

  // NOTE: every sequential process uses non-blocking assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the next-state default is assigned first so no path through the
  // case leaves it unassigned (which would infer a latch).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_next = w_fault ? S_RESP : S_ISSUE;
      S_ISSUE:   w_state_next = r_write ? S_RESP : S_CAPTURE;
      S_CAPTURE: w_state_next = S_RESP;
      S_RESP:    if (resp_ready) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset as well, because the response
  // and memory outputs are read straight from them and must be 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write       <= 1'b0;
      r_byte        <= 1'b0;
      r_signed      <= 1'b0;
      r_addr        <= 16'h0000;
      r_wdata       <= 16'h0000;
      r_rd          <= 3'd0;
      r_load        <= 1'b0;
      r_fault       <= 1'b0;
      r_resp_data   <= 16'h0000;
      r_fault_count <= '0;
    end else begin
      if (w_accept) begin
        r_write     <= req_write;
        r_byte      <= req_byte;
        r_signed    <= req_signed;
        r_addr      <= req_addr;
        r_wdata     <= req_wdata;
        r_rd        <= req_rd;
        r_load      <= !req_write;
        r_fault     <= w_fault;
        // Stores and faults answer with 0; loads overwrite this in CAPTURE.
        r_resp_data <= 16'h0000;
        if (w_fault && (r_fault_count != '1)) begin
          r_fault_count <= r_fault_count + FCNT_ONE;
        end
      end
      if (r_state == S_CAPTURE) begin
        if (!r_byte) begin
          r_resp_data <= mem_data_out;
        end else if (r_signed) begin
          r_resp_data <= {{8{mem_data_out[7]}}, mem_data_out[7:0]};
        end else begin
          r_resp_data <= {8'h00, mem_data_out[7:0]};
        end
      end
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign resp_valid  = (r_state == S_RESP);
  assign resp_data   = r_resp_data;
  assign resp_rd     = r_rd;
  assign resp_load   = r_load;
  assign resp_fault  = r_fault;
  assign fault_count = r_fault_count;

  // Strobes are decoded from the state register, so the asynchronous reset
  // removes them at once and a store cut by reset never reaches memory.
  assign dm_enable   = (r_state == S_ISSUE);
  assign mem_read    = dm_enable && !r_write;
  assign mem_write   = dm_enable && r_write;
  assign mem_byte    = dm_enable && r_byte;
  assign mem_address = r_addr;
  assign mem_data_in = r_byte ? {8'h00, r_wdata[7:0]} : r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Bench for load_store_unit. A byte-array data memory with one-cycle
// registered reads is attached to the main instance. A second instance with
// a 2-bit fault counter covers counter saturation. Expected responses come
// from a reference byte array, updated per request from the address and
// extension rules.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int MEM_BYTES = 512;
  localparam int FCNT_W    = 8;
  localparam int FCNT_MAX  = (1 << FCNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic              req_valid, req_write, req_byte, req_signed;
  logic [15:0]       req_addr, req_wdata;
  logic [2:0]        req_rd;
  logic              req_ready;
  logic              resp_valid, resp_ready, resp_load, resp_fault;
  logic [15:0]       resp_data;
  logic [2:0]        resp_rd;
  logic [FCNT_W-1:0] fault_count;
  logic              dm_enable, mem_read, mem_write, mem_byte;
  logic [15:0]       mem_address, mem_data_in, mem_rdata;

  load_store_unit #(.MEM_BYTES(MEM_BYTES), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_load(resp_load), .resp_fault(resp_fault),
    .fault_count(fault_count),
    .dm_enable(dm_enable), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte(mem_byte), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_rdata)
  );

  // Second instance: 2-bit fault counter, no memory behind it.
  logic        req_valid_2, req_ready_2, resp_valid_2, resp_ready_2;
  logic        resp_load_2, resp_fault_2;
  logic [15:0] resp_data_2;
  logic [2:0]  resp_rd_2;
  logic [1:0]  fault_count_2;
  logic        dm_enable_2, mem_read_2, mem_write_2, mem_byte_2;
  logic [15:0] mem_address_2, mem_data_in_2;
  logic [15:0] mem_rdata_2 = 16'h0000;

  load_store_unit #(.MEM_BYTES(MEM_BYTES), .FCNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_2), .req_ready(req_ready_2), .req_write(1'b0),
    .req_byte(1'b0), .req_signed(1'b0), .req_addr(16'h0011),
    .req_wdata(16'h0000), .req_rd(3'd5),
    .resp_valid(resp_valid_2), .resp_ready(resp_ready_2), .resp_data(resp_data_2),
    .resp_rd(resp_rd_2), .resp_load(resp_load_2), .resp_fault(resp_fault_2),
    .fault_count(fault_count_2),
    .dm_enable(dm_enable_2), .mem_read(mem_read_2), .mem_write(mem_write_2),
    .mem_byte(mem_byte_2), .mem_address(mem_address_2),
    .mem_data_in(mem_data_in_2), .mem_data_out(mem_rdata_2)
  );

  // -------------------------------------------------------------------------
  // Data memory: little-endian bytes, read data valid only in the cycle after
  // the read edge and 0 otherwise.
  // -------------------------------------------------------------------------
  logic [7:0] bus_mem [MEM_BYTES];
  logic       mem_ready = 1'b0;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 73 + 29) ^ (i >> 2));
  endfunction

  always @(posedge clk) begin
    logic [8:0] lo_idx;
    logic [8:0] hi_idx;
    lo_idx = mem_address[8:0];
    hi_idx = lo_idx + 9'd1;
    mem_rdata <= 16'h0000;
    if (!mem_ready) begin
      for (int i = 0; i < MEM_BYTES; i++) bus_mem[i] <= init_byte(i);
      mem_ready <= 1'b1;
    end else begin
      if (dm_enable && mem_read) begin
        mem_rdata <= mem_byte ? {8'h00, bus_mem[lo_idx]}
                              : {bus_mem[hi_idx], bus_mem[lo_idx]};
      end
      if (dm_enable && mem_write) begin
        bus_mem[lo_idx] <= mem_data_in[7:0];
        if (!mem_byte) bus_mem[hi_idx] <= mem_data_in[15:8];
      end
    end
  end

  // Strobe counters sampled at each active edge.
  int cnt_dm = 0, cnt_rd = 0, cnt_wr = 0;
  always @(posedge clk) begin
    if (dm_enable) cnt_dm++;
    if (mem_read)  cnt_rd++;
    if (mem_write) cnt_wr++;
  end

  // -------------------------------------------------------------------------
  // Reference model state
  // -------------------------------------------------------------------------
  logic [7:0] ref_mem [MEM_BYTES];
  int         exp_fcnt = 0;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " req_ready"},   32'(req_ready),   32'd1);
    check({tag, " resp_valid"},  32'(resp_valid),  32'd0);
    check({tag, " resp_data"},   32'(resp_data),   32'd0);
    check({tag, " resp_rd"},     32'(resp_rd),     32'd0);
    check({tag, " resp_load"},   32'(resp_load),   32'd0);
    check({tag, " resp_fault"},  32'(resp_fault),  32'd0);
    check({tag, " fault_count"}, 32'(fault_count), 32'd0);
    check({tag, " dm_enable"},   32'(dm_enable),   32'd0);
    check({tag, " mem_read"},    32'(mem_read),    32'd0);
    check({tag, " mem_write"},   32'(mem_write),   32'd0);
    check({tag, " mem_byte"},    32'(mem_byte),    32'd0);
    check({tag, " mem_address"}, 32'(mem_address), 32'd0);
    check({tag, " mem_data_in"}, 32'(mem_data_in), 32'd0);
  endtask

  // One complete request: model, drive, follow it to the response handshake
  // (holding resp_ready low for bp cycles), then check side effects.
  task automatic run_req(input string tag, input logic w, input logic b,
                         input logic s, input logic [15:0] a,
                         input logic [15:0] wd, input logic [2:0] rd,
                         input int bp);
    logic        exp_fault;
    int          exp_lat;
    logic [15:0] exp_data;
    logic [7:0]  lo, hi;
    int          dm0, rd0, wr0, k;

    exp_fault = b ? (int'(a) >= MEM_BYTES) : (a[0] || (int'(a) > MEM_BYTES - 2));
    exp_lat   = exp_fault ? 1 : (w ? 2 : 3);
    exp_data  = 16'h0000;
    if (!exp_fault) begin
      lo = ref_mem[int'(a)];
      hi = b ? 8'h00 : ref_mem[int'(a) + 1];
      if (!w) begin
        if (!b)     exp_data = {hi, lo};
        else if (s) exp_data = {{8{lo[7]}}, lo};
        else        exp_data = {8'h00, lo};
      end else begin
        ref_mem[int'(a)] = wd[7:0];
        if (!b) ref_mem[int'(a) + 1] = wd[15:8];
      end
    end else if (exp_fcnt < FCNT_MAX) begin
      exp_fcnt++;
    end

    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_byte = b; req_signed = s;
    req_addr = a; req_wdata = wd; req_rd = rd;
    resp_ready = (bp == 0);
    check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    dm0 = cnt_dm; rd0 = cnt_rd; wr0 = cnt_wr;
    @(posedge clk);
    @(negedge clk);
    // Scramble the inputs so only latched values can produce correct results.
    req_valid = 1'b0; req_write = 1'($urandom); req_byte = 1'($urandom);
    req_signed = 1'($urandom); req_addr = 16'($urandom);
    req_wdata = 16'($urandom); req_rd = 3'($urandom);
    k = 1;
    while (!resp_valid && k < 8) begin
      check({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
      if (k == 1 && !exp_fault) begin
        check({tag, " issue dm_enable"},   32'(dm_enable),   32'd1);
        check({tag, " issue mem_address"}, 32'(mem_address), 32'(a));
        check({tag, " issue mem_byte"},    32'(mem_byte),    32'(b));
        check({tag, " issue mem_write"},   32'(mem_write),   32'(w));
        if (w) check({tag, " issue mem_data_in"}, 32'(mem_data_in),
                     32'(b ? {8'h00, wd[7:0]} : wd));
      end
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'(exp_lat));
    for (int i = 0; i <= bp; i++) begin
      check({tag, " resp_valid"},  32'(resp_valid), 32'd1);
      check({tag, " resp_data"},   32'(resp_data),  32'(exp_data));
      check({tag, " resp_rd"},     32'(resp_rd),    32'(rd));
      check({tag, " resp_load"},   32'(resp_load),  32'(!w));
      check({tag, " resp_fault"},  32'(resp_fault), 32'(exp_fault));
      check({tag, " req_ready resp"}, 32'(req_ready), 32'd0);
      if (i == bp) resp_ready = 1'b1;
      @(negedge clk);
    end
    check({tag, " resp_valid drop"}, 32'(resp_valid),  32'd0);
    check({tag, " req_ready back"},  32'(req_ready),   32'd1);
    check({tag, " fault_count"},     32'(fault_count), 32'(exp_fcnt));
    check({tag, " dm pulses"},   32'(cnt_dm - dm0), 32'(exp_fault ? 0 : 1));
    check({tag, " read pulses"}, 32'(cnt_rd - rd0), 32'((!exp_fault && !w) ? 1 : 0));
    check({tag, " write pulses"},32'(cnt_wr - wr0), 32'((!exp_fault && w) ? 1 : 0));
    if (w && !exp_fault) begin
      check({tag, " mem lo"}, 32'(bus_mem[int'(a)]), 32'(ref_mem[int'(a)]));
      if (!b) check({tag, " mem hi"}, 32'(bus_mem[int'(a) + 1]), 32'(ref_mem[int'(a) + 1]));
    end
  endtask

  initial begin
    logic        w, b, s;
    logic [15:0] a;
    int          sel;

    req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 16'h0; req_wdata = 16'h0; req_rd = 3'd0; resp_ready = 1'b1;
    req_valid_2 = 1'b0; resp_ready_2 = 1'b1;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);

    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;

    // Word store then load
    run_req("st_word", 1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 3'd1, 0);
    check("mem 0x10", 32'(bus_mem[16]), 32'h00EF);
    check("mem 0x11", 32'(bus_mem[17]), 32'h00BE);
    run_req("ld_word", 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 3'd2, 0);

    // Byte load extension
    run_req("st_byte", 1'b1, 1'b1, 1'b0, 16'h0021, 16'h3385, 3'd3, 0);
    check("mem 0x21", 32'(bus_mem[33]), 32'h0085);
    run_req("ld_sbyte", 1'b0, 1'b1, 1'b1, 16'h0021, 16'h0000, 3'd4, 0);
    run_req("ld_ubyte", 1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 3'd5, 0);
    run_req("ld_w20",   1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 3'd6, 0);

    // Faults
    run_req("flt_ld11",  1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 3'd7, 0);
    run_req("flt_sb200", 1'b1, 1'b1, 1'b0, 16'h0200, 16'h00AA, 3'd1, 0);
    run_req("flt_sw1ff", 1'b1, 1'b0, 1'b0, 16'h01FF, 16'h5555, 3'd2, 0);
    check("fault_count after 3", 32'(fault_count), 32'd3);

    // Edge addresses that are still legal
    run_req("sb_1ff", 1'b1, 1'b1, 1'b0, 16'h01FF, 16'h1177, 3'd3, 0);
    run_req("lw_1fe", 1'b0, 1'b0, 1'b0, 16'h01FE, 16'h0000, 3'd4, 0);

    // Backpressure
    run_req("ld_bp", 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 3'd6, 5);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      w = 1'($urandom); b = 1'($urandom); s = 1'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       a = 16'($urandom_range(0, 63));
      else if (sel == 7) a = 16'($urandom_range(500, 520));
      else               a = 16'($urandom);
      if (!b && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      run_req($sformatf("rnd%0d", n), w, b, s, a, 16'($urandom), 3'($urandom),
              int'($urandom_range(0, 3)));
    end

    // Reset during the ISSUE cycle of a store
    run_req("st_30", 1'b1, 1'b0, 1'b0, 16'h0030, 16'h5A5A, 3'd1, 0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 16'h0030; req_wdata = 16'h1234; req_rd = 3'd2; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst issue dm_enable", 32'(dm_enable), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_values("rst mid");
    exp_fcnt = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst mem 0x30", 32'(bus_mem[48]), 32'(ref_mem[48]));
    check("rst mem 0x31", 32'(bus_mem[49]), 32'(ref_mem[49]));
    rst_n = 1'b1;
    run_req("post_rst_ld", 1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000, 3'd3, 0);

    // Saturation of a 2-bit fault counter
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("sat%0d req_ready", i), 32'(req_ready_2), 32'd1);
      req_valid_2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid_2 = 1'b0;
      check($sformatf("sat%0d resp_valid", i),  32'(resp_valid_2),  32'd1);
      check($sformatf("sat%0d resp_fault", i),  32'(resp_fault_2),  32'd1);
      check($sformatf("sat%0d resp_data", i),   32'(resp_data_2),   32'd0);
      check($sformatf("sat%0d fault_count", i), 32'(fault_count_2), 32'((i + 1 > 3) ? 3 : i + 1));
      check($sformatf("sat%0d dm_enable", i),   32'(dm_enable_2),   32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
